// File: rtl/audio_pkg.sv
// Shared audio constants and the two's-complement to offset-binary helper
// used by the PDM output path.
package audio_pkg;

    localparam int CODE_WIDTH     = 14;
    localparam int SAMPLE_DIV_48K = 2604;  // 125 MHz / 2604 ~= 48 kHz
    localparam int CNT_WIDTH_48K  = 12;

    localparam logic [CODE_WIDTH-1:0] MIDSCALE = {1'b1, {(CODE_WIDTH-1){1'b0}}};

    // Flipping the sign bit maps -2^(N-1)..2^(N-1)-1 onto 0..2^N-1.
    function automatic logic [CODE_WIDTH-1:0] to_offset_binary(
        input logic signed [CODE_WIDTH-1:0] s
    );
        return {~s[CODE_WIDTH-1], s[CODE_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/sigma_delta_mod.sv
// First-order sigma-delta modulator: the accumulator carry is the 1-bit
// output, so the pulse density equals code / 2^CODE_WIDTH.
module sigma_delta_mod
    import audio_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CODE_WIDTH-1:0] code,
    output logic                  pdm_out
);

    logic [CODE_WIDTH-1:0] acc;
    logic [CODE_WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, code};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would let acc feed itself within one edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc     <= '0;
            pdm_out <= 1'b0;
        end else begin
            acc     <= sum[CODE_WIDTH-1:0];
            pdm_out <= sum[CODE_WIDTH];
        end
    end

endmodule

// File: rtl/audio_pdm_dac.sv
// Paces sample requests, captures and attenuates the returned sample, and
// feeds the offset-binary code to the sigma-delta modulator.
module audio_pdm_dac
    import audio_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_48K,
    parameter int CNT_WIDTH  = CNT_WIDTH_48K
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            vol_shift,
    output logic                  next_sample,
    input  logic [CODE_WIDTH-1:0] sample,
    output logic                  sample_strobe,
    output logic                  pdm_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SAMPLE_DIV - 1);

    logic [CNT_WIDTH-1:0]         cnt;
    logic                         pending;
    logic [CODE_WIDTH-1:0]        code;
    logic signed [CODE_WIDTH-1:0] scaled;

    always_comb begin
        scaled = $signed(sample) >>> vol_shift;
    end

    // pending marks the cycle the source's answer is valid; clearing it on
    // disable or reset is what drops an in-flight capture.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            cnt           <= '0;
            next_sample   <= 1'b0;
            pending       <= 1'b0;
            sample_strobe <= 1'b0;
            code          <= MIDSCALE;
        end else begin
            cnt           <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            next_sample   <= (cnt == '0);
            pending       <= next_sample;
            sample_strobe <= pending;
            if (pending) begin
                code <= to_offset_binary(scaled);
            end
        end
    end

    sigma_delta_mod u_mod (
        .clk     (clk),
        .rst     (rst),
        .code    (code),
        .pdm_out (pdm_out)
    );

endmodule
